// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory side (slave).
interface mc_control_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  opcode;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src;
  logic [OP_W:0]    alu_op;
  logic             branch;
  logic             jump;
  logic [1:0]       mem_read;
  logic [1:0]       mem_write;
  logic             mem_to_reg;
  logic             mem_err;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_o;

  modport master (
    input  opcode, mem_ready,
    output ir_write, pc_write, reg_write, reg_dst, alu_src, alu_op, branch, jump,
           mem_read, mem_write, mem_to_reg, mem_err, illegal_op, retired, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  ir_write, pc_write, reg_write, reg_dst, alu_src, alu_op, branch, jump,
           mem_read, mem_write, mem_to_reg, mem_err, illegal_op, retired, state_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB/BRJ with memory wait timeout.
// Define ILLEGAL_TRAP_EN to park in TRAP on unknown opcodes instead of treating them as NOPs.
module mc_control_fsm #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_BRJ = 3'd5, S_TRAP = 3'd6
  } state_t;

  typedef enum logic [2:0] {C_R, C_BR, C_J, C_IMM, C_LD, C_ST, C_ILL} cls_t;

  typedef struct packed {
    logic          reg_write;
    logic          reg_dst;
    logic          alu_src;
    logic [OP_W:0] alu_op;
    logic          branch;
    logic          jump;
    logic          pc_write;
    logic [1:0]    mem_read;
    logic [1:0]    mem_write;
    logic          mem_to_reg;
  } ctrl_t;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  cls_t             cls;
  logic [OP_W-1:0]  op_q, cur_op;
  logic [7:0]       wcnt_q;
  logic             timeout, fetch_done, mem_err_d, retire;
  logic [CNT_W-1:0] retired_q;

  function automatic cls_t classify(input logic [OP_W-1:0] op);
    case (int'(op))
      0:                 return C_R;
      1, 4, 5:           return C_BR;
      2, 3:              return C_J;
      8, 10, 12, 13, 14: return C_IMM;
      32, 33, 35:        return C_LD;
      40, 41, 43:        return C_ST;
      default:           return C_ILL;
    endcase
  endfunction

  function automatic logic [1:0] mem_size(input logic [OP_W-1:0] op);
    case (int'(op))
      32, 40:  return 2'b01;
      33, 41:  return 2'b10;
      35, 43:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // The IR is written at the end of FETCH, so the live opcode is only trusted in DECODE.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = '0;
    fetch_done = 1'b0;
    mem_err_d  = 1'b0;
    retire     = 1'b0;
    cur_op     = (state_q == S_DECODE) ? bus.opcode : op_q;
    cls        = classify(cur_op);
    timeout    = (wcnt_q == 8'(TIMEOUT - 1)) && !bus.mem_ready;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          fetch_done = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          mem_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (cls)
          C_R, C_IMM, C_LD, C_ST: state_d = S_EXEC;
          C_BR, C_J:              state_d = S_BRJ;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC: state_d = (cls == C_LD || cls == C_ST) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready) begin
          if (cls == C_LD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (timeout) begin
          mem_err_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB, S_BRJ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Phase controls are decoded from the next state and registered with it.
    case (state_d)
      S_EXEC: begin
        ctrl_d.reg_dst = (cls == C_R);
        ctrl_d.alu_src = (cls != C_R);
        ctrl_d.alu_op  = (cls == C_R) ? '0 : {1'b1, cur_op};
      end
      S_MEM: begin
        if (cls == C_LD) ctrl_d.mem_read  = mem_size(cur_op);
        else             ctrl_d.mem_write = mem_size(cur_op);
      end
      S_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = (cls == C_LD);
        ctrl_d.reg_dst    = (cls == C_R);
      end
      S_BRJ: begin
        if (cls == C_BR) begin
          ctrl_d.branch = 1'b1;
          ctrl_d.alu_op = {1'b1, cur_op};
        end else begin
          ctrl_d.jump     = 1'b1;
          ctrl_d.pc_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= '0;
      op_q      <= '0;
      wcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      // Count only while still waiting in the same memory phase; any exit or abort restarts it.
      if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q && !mem_err_d)
        wcnt_q <= wcnt_q + 8'd1;
      else
        wcnt_q <= '0;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= (state_d == S_TRAP) && (state_q != S_TRAP);
  end
  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

  assign bus.ir_write   = fetch_done & rst_n;
  assign bus.pc_write   = ctrl_q.pc_write | (fetch_done & rst_n);
  assign bus.mem_err    = mem_err_d & rst_n;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.branch     = ctrl_q.branch;
  assign bus.jump       = ctrl_q.jump;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.retired    = retired_q;
  assign bus.state_o    = state_q;
endmodule
